// File: rtl/fir_pkg.sv
// fir_pkg: shared constants and types for the FIR stream feeder.
//   - AXI-Lite register offsets (ctrl, length, base)
//   - ctrl register bit indices
//   - feeder FSM state encoding
package fir_pkg;

  localparam int unsigned REG_CTRL = 32'h000;
  localparam int unsigned REG_LEN  = 32'h010;
  localparam int unsigned REG_BASE = 32'h014;

  localparam int unsigned CTRL_START_BIT = 0;
  localparam int unsigned CTRL_DONE_BIT  = 1;
  localparam int unsigned CTRL_IDLE_BIT  = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } feed_state_e;

endpackage : fir_pkg

// File: rtl/fir_feed_fifo.sv
// fir_feed_fifo: 2-entry synchronous FIFO absorbing the sample BRAM read latency.
// Ports:
//   i_clk, i_rst_n  clock, asynchronous active-low reset (empties the FIFO)
//   i_push, i_data  write side; a push while full is accepted only with a pop
//   i_pop           read side; ignored while empty
//   o_data          head entry (valid when o_count != 0)
//   o_count         number of stored entries (0..2)
module fir_feed_fifo #(
  parameter int W = 32
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic [1:0]   o_count
);

  logic [W-1:0] r_mem [2];
  logic         r_wr_ptr;
  logic         r_rd_ptr;
  logic [1:0]   r_count;

  logic w_do_pop;
  logic w_do_push;

  assign w_do_pop  = i_pop && (r_count != 2'd0);
  // When full, a simultaneous pop frees the slot the push is about to use.
  assign w_do_push = i_push && ((r_count != 2'd2) || w_do_pop);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_do_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule : fir_feed_fifo

// File: rtl/fir_stream_feeder.sv
// fir_stream_feeder: reads `length` 32-bit samples from a word-organised
// sample BRAM starting at `base` and streams them to the FIR ss_* port.
// Ports:
//   axis_clk, axis_rst_n          clock, asynchronous active-low reset
//   aw*/w*/ar*/r*                 AXI-Lite slave: 0x00 ctrl, 0x10 length, 0x14 base
//   m_tvalid/m_tready/m_tdata/m_tlast  AXI-Stream master toward the FIR
//   smp_EN/smp_A/smp_Do           sample BRAM read port (data valid one cycle after EN)
//   o_dbg_state                   current feeder FSM state
//
// Handshakes: every channel transfers on a rising edge where valid and ready
// are both high; a source holds valid and its payload stable until that edge.
// awready/wready pulse together for one cycle only when both awvalid and
// wvalid are present; arready pulses only while no read response is pending.
module fir_stream_feeder
  import fir_pkg::*;
#(
  parameter int pADDR_WIDTH = 12,
  parameter int pDATA_WIDTH = 32
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  input  logic                   awvalid,
  output logic                   awready,
  input  logic [pADDR_WIDTH-1:0] awaddr,
  input  logic                   wvalid,
  output logic                   wready,
  input  logic [pDATA_WIDTH-1:0] wdata,
  input  logic                   arvalid,
  output logic                   arready,
  input  logic [pADDR_WIDTH-1:0] araddr,
  output logic                   rvalid,
  input  logic                   rready,
  output logic [pDATA_WIDTH-1:0] rdata,
  output logic                   m_tvalid,
  input  logic                   m_tready,
  output logic [pDATA_WIDTH-1:0] m_tdata,
  output logic                   m_tlast,
  output logic                   smp_EN,
  output logic [pADDR_WIDTH-1:0] smp_A,
  input  logic [pDATA_WIDTH-1:0] smp_Do,
  output logic [1:0]             o_dbg_state
);

  feed_state_e r_state;
  feed_state_e w_state_nxt;

  logic                   r_awready;
  logic                   r_arready;
  logic                   r_rvalid;
  logic [pDATA_WIDTH-1:0] r_rdata;
  logic [31:0]            r_len;
  logic [pADDR_WIDTH-1:0] r_base;
  logic                   r_ap_start;
  logic                   r_ap_done;
  logic [31:0]            r_idx;
  logic [31:0]            r_beat;
  logic                   r_inflight;

  logic                   w_wr;
  logic                   w_rd;
  logic                   w_idle;
  logic                   w_start;
  logic                   w_finish;
  logic                   w_issue;
  logic                   w_last_issue;
  logic                   w_last_beat;
  logic                   w_tvalid;
  logic                   w_pop;
  logic [1:0]             w_fifo_count;
  logic [2:0]             w_slots_used;
  logic [pDATA_WIDTH-1:0] w_fifo_data;
  logic [pDATA_WIDTH-1:0] w_rdata_mux;

  // ---------------- AXI-Lite decode ----------------
  assign w_wr    = awvalid && wvalid && r_awready;
  assign w_rd    = arvalid && r_arready;
  assign w_idle  = (r_state == ST_IDLE);
  assign w_start = w_wr && w_idle && (awaddr == pADDR_WIDTH'(REG_CTRL))
                   && wdata[CTRL_START_BIT];

  // ---------------- stream datapath ----------------
  assign w_tvalid = (w_fifo_count != 2'd0);
  assign w_pop    = w_tvalid && m_tready;

  // Occupancy the FIFO will see once outstanding reads land. A beat leaving
  // this cycle is credited so the slot it frees can be refilled immediately,
  // which is what sustains one beat per cycle.
  assign w_slots_used = {1'b0, w_fifo_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_issue      = (r_state == ST_RUN) && (w_slots_used < 3'd2);
  assign w_last_issue = w_issue && (r_idx == r_len - 32'd1);
  assign w_last_beat  = w_pop && (r_beat == r_len - 32'd1);

  fir_feed_fifo #(.W(pDATA_WIDTH)) u_fifo (
    .i_clk   (axis_clk),
    .i_rst_n (axis_rst_n),
    .i_push  (r_inflight),
    .i_data  (smp_Do),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_count (w_fifo_count)
  );

  // ---------------- FSM: next state ----------------
  always_comb begin
    w_state_nxt = r_state;
    w_finish    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          w_state_nxt = (r_len != 32'd0) ? ST_RUN : ST_DONE;
        end
      end
      ST_RUN: begin
        if (w_last_issue) begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Completion lands directly in IDLE on the final accept edge.
        if (w_last_beat) begin
          w_state_nxt = ST_IDLE;
          w_finish    = 1'b1;
        end
      end
      ST_DONE: begin
        // Only reached by a zero-length start.
        w_state_nxt = ST_IDLE;
        w_finish    = 1'b1;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------- control / status and address generator ----------------
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      r_len      <= 32'd0;
      r_base     <= '0;
      r_ap_start <= 1'b0;
      r_ap_done  <= 1'b0;
      r_idx      <= 32'd0;
      r_beat     <= 32'd0;
      r_inflight <= 1'b0;
    end else begin
      if (w_wr && w_idle && (awaddr == pADDR_WIDTH'(REG_LEN))) begin
        r_len <= 32'(wdata);
      end
      if (w_wr && w_idle && (awaddr == pADDR_WIDTH'(REG_BASE))) begin
        r_base <= {wdata[pADDR_WIDTH-1:2], 2'b00};
      end

      // A non-empty start enters RUN on the write edge, so ap_start is
      // already self-cleared; it is only visible during a zero-length run.
      if (w_start && (r_len == 32'd0)) begin
        r_ap_start <= 1'b1;
      end else if (w_finish) begin
        r_ap_start <= 1'b0;
      end

      if (w_start) begin
        r_ap_done <= 1'b0;
      end else if (w_finish) begin
        r_ap_done <= 1'b1;
      end else if (w_rd && (araddr == pADDR_WIDTH'(REG_CTRL))) begin
        r_ap_done <= 1'b0;
      end

      if (w_start) begin
        r_idx <= 32'd0;
      end else if (w_issue) begin
        r_idx <= r_idx + 32'd1;
      end

      if (w_start) begin
        r_beat <= 32'd0;
      end else if (w_pop) begin
        r_beat <= r_beat + 32'd1;
      end

      r_inflight <= w_issue;
    end
  end

  // ---------------- AXI-Lite channels ----------------
  always_comb begin
    w_rdata_mux = '0;
    if (araddr == pADDR_WIDTH'(REG_CTRL)) begin
      w_rdata_mux[CTRL_START_BIT] = r_ap_start;
      w_rdata_mux[CTRL_DONE_BIT]  = r_ap_done;
      w_rdata_mux[CTRL_IDLE_BIT]  = w_idle;
    end else if (araddr == pADDR_WIDTH'(REG_LEN)) begin
      w_rdata_mux = pDATA_WIDTH'(r_len);
    end else if (araddr == pADDR_WIDTH'(REG_BASE)) begin
      w_rdata_mux = pDATA_WIDTH'(r_base);
    end
  end

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      r_awready <= 1'b0;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
    end else begin
      r_awready <= awvalid && wvalid && !r_awready;
      r_arready <= arvalid && !r_arready && !r_rvalid;
      if (w_rd) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rdata_mux;
      end else if (r_rvalid && rready) begin
        r_rvalid <= 1'b0;
      end
    end
  end

  // ---------------- outputs ----------------
  assign awready     = r_awready;
  assign wready      = r_awready;
  assign arready     = r_arready;
  assign rvalid      = r_rvalid;
  assign rdata       = r_rdata;
  assign m_tvalid    = w_tvalid;
  assign m_tdata     = w_fifo_data;
  assign m_tlast     = w_tvalid && (r_beat == r_len - 32'd1);
  assign smp_EN      = w_issue;
  assign smp_A       = w_issue ? (r_base + {r_idx[pADDR_WIDTH-3:0], 2'b00}) : '0;
  assign o_dbg_state = r_state;

endmodule : fir_stream_feeder

// File: tb/tb_fir_stream_feeder.sv
// Directed testbench for fir_stream_feeder with a behavioural sample BRAM
// (word i holds 10 + i) and a stream monitor that logs accepted beats.
module tb_fir_stream_feeder;

  localparam int AW = 12;
  localparam int DW = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic [AW-1:0] awaddr = '0, araddr = '0;
  logic [DW-1:0] wdata = '0;
  logic          awready, wready, arready, rvalid;
  logic [DW-1:0] rdata;
  logic          m_tvalid, m_tlast;
  logic          m_tready = 1'b1;
  logic [DW-1:0] m_tdata;
  logic          smp_EN;
  logic [AW-1:0] smp_A;
  logic [DW-1:0] smp_Do = '0;
  logic [1:0]    dbg_state;

  fir_stream_feeder #(.pADDR_WIDTH(AW), .pDATA_WIDTH(DW)) dut (
    .axis_clk(clk), .axis_rst_n(rst_n),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tlast(m_tlast),
    .smp_EN(smp_EN), .smp_A(smp_A), .smp_Do(smp_Do),
    .o_dbg_state(dbg_state)
  );

  // ---------------- sample BRAM model ----------------
  logic [DW-1:0] mem [1024];
  initial for (int i = 0; i < 1024; i++) mem[i] = 32'(10 + i);
  always @(posedge clk) if (smp_EN) smp_Do <= mem[smp_A[AW-1:2]];

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int failures = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] got_q[$];
  logic          got_last_q[$];
  int            got_cyc_q[$];
  logic [AW-1:0] addr_q[$];
  int            cyc = 0;
  logic          toggle_en = 1'b0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic          prev_last = 1'b0;
  logic [DW-1:0] rd_val;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- monitor (samples on falling edge) ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      cyc++;
      if (prev_stall) begin
        check("stall_valid", 32'(m_tvalid), 32'd1);
        check("stall_data", m_tdata, prev_data);
        check("stall_last", 32'(m_tlast), 32'(prev_last));
      end
      if (m_tvalid && m_tready) begin
        got_q.push_back(m_tdata);
        got_last_q.push_back(m_tlast);
        got_cyc_q.push_back(cyc);
      end
      if (smp_EN) addr_q.push_back(smp_A);
      prev_stall = m_tvalid && !m_tready;
      prev_data  = m_tdata;
      prev_last  = m_tlast;
    end else begin
      prev_stall = 1'b0;
    end
  end

  always @(posedge clk) begin
    #1;
    if (toggle_en) m_tready = !m_tready;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time exceeded");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic axi_write(input logic [AW-1:0] addr, input logic [DW-1:0] data);
    logic ok = 1'b0;
    @(posedge clk); #1;
    awaddr = addr; wdata = data; awvalid = 1'b1; wvalid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (awready && wready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    check("wr_handshake", 32'(ok), 32'd1);
  endtask

  task automatic axi_read(input logic [AW-1:0] addr, output logic [DW-1:0] data);
    logic ok_a = 1'b0;
    logic ok_r = 1'b0;
    data = '0;
    @(posedge clk); #1;
    araddr = addr; arvalid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (arready) begin ok_a = 1'b1; break; end
    end
    @(posedge clk); #1;
    arvalid = 1'b0; rready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rvalid) begin ok_r = 1'b1; data = rdata; break; end
    end
    @(posedge clk); #1;
    rready = 1'b0;
    check("rd_handshake", 32'(ok_a && ok_r), 32'd1);
  endtask

  task automatic wait_beats(input string tag, input int n, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (got_q.size() >= n) break;
    end
    check(tag, 32'(got_q.size()), 32'(n));
  endtask

  task automatic clear_logs();
    got_q.delete(); got_last_q.delete(); got_cyc_q.delete(); addr_q.delete();
  endtask

  task automatic check_stream(input string tag);
    check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check({tag, "_data"}, got_q[i], exp_q[i]);
      check({tag, "_last"}, 32'(got_last_q[i]), 32'(i == exp_q.size() - 1));
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    // Reset values
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_awready", 32'(awready), 32'd0);
    check("rst_wready", 32'(wready), 32'd0);
    check("rst_arready", 32'(arready), 32'd0);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_tvalid", 32'(m_tvalid), 32'd0);
    check("rst_tdata", m_tdata, 32'd0);
    check("rst_tlast", 32'(m_tlast), 32'd0);
    check("rst_smp_en", 32'(smp_EN), 32'd0);
    check("rst_smp_a", 32'(smp_A), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    axi_read(12'h000, rd_val); check("rst_ctrl", rd_val, 32'h4);
    axi_read(12'h010, rd_val); check("rst_len", rd_val, 32'h0);
    axi_read(12'h014, rd_val); check("rst_base", rd_val, 32'h0);
    axi_read(12'h020, rd_val); check("unmapped_rd", rd_val, 32'h0);

    // Test 1: length 5, base 0, tready high
    axi_write(12'h010, 32'd5);
    axi_write(12'h014, 32'h000);
    axi_read(12'h010, rd_val); check("t1_len_rb", rd_val, 32'd5);
    clear_logs();
    axi_write(12'h000, 32'h1);
    @(negedge clk);
    check("t1_lat_en", 32'(smp_EN), 32'd1);
    check("t1_lat_a", 32'(smp_A), 32'h000);
    check("t1_lat_v1", 32'(m_tvalid), 32'd0);
    @(negedge clk);
    check("t1_lat_v2", 32'(m_tvalid), 32'd0);
    @(negedge clk);
    check("t1_lat_v3", 32'(m_tvalid), 32'd1);
    check("t1_lat_d3", m_tdata, 32'd10);
    wait_beats("t1_wait", 5, 50);
    exp_q = '{32'd10, 32'd11, 32'd12, 32'd13, 32'd14};
    check_stream("t1");
    for (int i = 1; i < got_cyc_q.size(); i++)
      check("t1_consecutive", 32'(got_cyc_q[i] - got_cyc_q[0]), 32'(i));
    repeat (2) @(negedge clk);
    axi_read(12'h000, rd_val); check("t1_ctrl_done", rd_val, 32'h6);
    axi_read(12'h000, rd_val); check("t1_ctrl_clr", rd_val, 32'h4);

    // Test 2: same run with tready toggling every cycle
    clear_logs();
    toggle_en = 1'b1;
    axi_write(12'h000, 32'h1);
    wait_beats("t2_wait", 5, 80);
    toggle_en = 1'b0;
    @(posedge clk); #1;
    m_tready = 1'b1;
    check_stream("t2");
    repeat (3) @(negedge clk);
    check("t2_no_extra", 32'(got_q.size()), 32'd5);
    axi_read(12'h000, rd_val); check("t2_ctrl_done", rd_val, 32'h6);

    // Test 3: base 0xFF8 wraps the 12-bit byte address
    axi_write(12'h010, 32'd4);
    axi_write(12'h014, 32'hFF8);
    clear_logs();
    axi_write(12'h000, 32'h1);
    wait_beats("t3_wait", 4, 50);
    exp_q = '{32'd1032, 32'd1033, 32'd10, 32'd11};
    check_stream("t3");
    check("t3_addr_count", 32'(addr_q.size()), 32'd4);
    if (addr_q.size() == 4) begin
      check("t3_addr0", 32'(addr_q[0]), 32'hFF8);
      check("t3_addr1", 32'(addr_q[1]), 32'hFFC);
      check("t3_addr2", 32'(addr_q[2]), 32'h000);
      check("t3_addr3", 32'(addr_q[3]), 32'h004);
    end
    repeat (2) @(negedge clk);

    // Test 4: zero length completes without beats
    axi_write(12'h010, 32'd0);
    clear_logs();
    axi_write(12'h000, 32'h1);
    axi_read(12'h000, rd_val); check("t4_ctrl_done", rd_val, 32'h6);
    axi_read(12'h000, rd_val); check("t4_ctrl_clr", rd_val, 32'h4);
    check("t4_no_beats", 32'(got_q.size()), 32'd0);
    check("t4_no_reads", 32'(addr_q.size()), 32'd0);

    // Test 5: register writes while busy are ignored
    axi_write(12'h010, 32'd8);
    axi_write(12'h014, 32'h000);
    m_tready = 1'b0;
    clear_logs();
    axi_write(12'h000, 32'h1);
    axi_write(12'h010, 32'd3);
    axi_write(12'h014, 32'h100);
    axi_read(12'h000, rd_val); check("t5_ctrl_busy", rd_val, 32'h0);
    @(posedge clk); #1;
    m_tready = 1'b1;
    wait_beats("t5_wait", 8, 60);
    exp_q = '{32'd10, 32'd11, 32'd12, 32'd13, 32'd14, 32'd15, 32'd16, 32'd17};
    check_stream("t5");
    repeat (2) @(negedge clk);
    axi_read(12'h010, rd_val); check("t5_len_kept", rd_val, 32'd8);
    axi_read(12'h014, rd_val); check("t5_base_kept", rd_val, 32'h0);
    axi_read(12'h000, rd_val); check("t5_ctrl_done", rd_val, 32'h6);

    // Test 6: reset while the third of six beats is presented
    axi_write(12'h010, 32'd6);
    clear_logs();
    axi_write(12'h000, 32'h1);
    wait_beats("t6_wait", 3, 40);
    check("t6_pre_valid", 32'(m_tvalid), 32'd1);
    check("t6_pre_data", m_tdata, 32'd12);
    #1;
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", 32'(m_tvalid), 32'd0);
    check("t6_rst_last", 32'(m_tlast), 32'd0);
    check("t6_rst_en", 32'(smp_EN), 32'd0);
    check("t6_rst_state", 32'(dbg_state), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    axi_read(12'h000, rd_val); check("t6_ctrl_rst", rd_val, 32'h4);
    axi_read(12'h010, rd_val); check("t6_len_rst", rd_val, 32'h0);
    axi_write(12'h010, 32'd2);
    clear_logs();
    axi_write(12'h000, 32'h1);
    wait_beats("t6_wait2", 2, 40);
    exp_q = '{32'd10, 32'd11};
    check_stream("t6");
    repeat (2) @(negedge clk);
    axi_read(12'h000, rd_val); check("t6_ctrl_done", rd_val, 32'h6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_fir_stream_feeder
